// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg_if
//  Description : Bundle of ID-side inputs, WB bypass inputs and EX-side
//                outputs of the ID/EX pipeline register.
//                master : the pipeline around the register (drives ID/WB,
//                         observes EX and flow control)
//                slave  : the ID/EX register itself
//  Ports       : Flush, IF_ID_Reg{Rs,Rt,Rd}, ID_UsesRt, ID_Valid, ID_Ctrl,
//                ID_RegData{1,2}, ID_Imm, MEM_WB_{RegWrite,RegRd,Data}  (to reg)
//                ID_EX_Reg{Rs,Rt,Rd}, ID_EX_Ctrl, ID_EX_Data{1,2},
//                ID_EX_Imm, ID_EX_Valid, Stall, PCWrite, IF_IDWrite,
//                StallCount                                      (from reg)
//  Revision    : 1.0  initial release
// ============================================================================
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // ID stage side
    logic              Flush;
    logic [REG_AW-1:0] IF_ID_RegRs;
    logic [REG_AW-1:0] IF_ID_RegRt;
    logic [REG_AW-1:0] IF_ID_RegRd;
    logic              ID_UsesRt;
    logic              ID_Valid;
    logic [7:0]        ID_Ctrl;
    logic [DATA_W-1:0] ID_RegData1;
    logic [DATA_W-1:0] ID_RegData2;
    logic [DATA_W-1:0] ID_Imm;
    // WB stage side (bypass source)
    logic              MEM_WB_RegWrite;
    logic [REG_AW-1:0] MEM_WB_RegRd;
    logic [DATA_W-1:0] MEM_WB_Data;
    // EX stage side
    logic [REG_AW-1:0] ID_EX_RegRs;
    logic [REG_AW-1:0] ID_EX_RegRt;
    logic [REG_AW-1:0] ID_EX_RegRd;
    logic [7:0]        ID_EX_Ctrl;
    logic [DATA_W-1:0] ID_EX_Data1;
    logic [DATA_W-1:0] ID_EX_Data2;
    logic [DATA_W-1:0] ID_EX_Imm;
    logic              ID_EX_Valid;
    // Flow control
    logic              Stall;
    logic              PCWrite;
    logic              IF_IDWrite;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output Flush, IF_ID_RegRs, IF_ID_RegRt, IF_ID_RegRd, ID_UsesRt,
               ID_Valid, ID_Ctrl, ID_RegData1, ID_RegData2, ID_Imm,
               MEM_WB_RegWrite, MEM_WB_RegRd, MEM_WB_Data,
        input  ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd, ID_EX_Ctrl,
               ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_Valid,
               Stall, PCWrite, IF_IDWrite, StallCount
    );

    modport slave (
        input  Flush, IF_ID_RegRs, IF_ID_RegRt, IF_ID_RegRd, ID_UsesRt,
               ID_Valid, ID_Ctrl, ID_RegData1, ID_RegData2, ID_Imm,
               MEM_WB_RegWrite, MEM_WB_RegRd, MEM_WB_Data,
        output ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd, ID_EX_Ctrl,
               ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_Valid,
               Stall, PCWrite, IF_IDWrite, StallCount
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg
//  Description : ID/EX pipeline register with load-use hazard detection,
//                WB->ID register-file bypass and a saturating stall counter.
//                A load in EX whose rt is read by the instruction in ID
//                produces one bubble while PC and IF/ID are frozen; a branch
//                flush squashes the entering instruction and overrides the
//                stall.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous, active-low reset
//                bus    - id_ex_stage_reg_if.slave (ID/WB inputs, EX outputs,
//                         Stall/PCWrite/IF_IDWrite/StallCount)
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    id_ex_stage_reg_if.slave  bus
);

    localparam int C_CTRL_MEMREAD = 2;

    logic [REG_AW-1:0] rs_q,    rs_d;
    logic [REG_AW-1:0] rt_q,    rt_d;
    logic [REG_AW-1:0] rd_q,    rd_d;
    logic [7:0]        ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              w_hazard;
    logic              w_stall;
    logic              w_bubble;
    logic [DATA_W-1:0] w_byp1;
    logic [DATA_W-1:0] w_byp2;

    // Load in EX whose destination (rt) is a source of the instruction in ID.
    // $0 is hard-wired, so a load targeting it can never create a dependency.
    assign w_hazard = valid_q && ctrl_q[C_CTRL_MEMREAD] && (rt_q != '0) &&
                      bus.ID_Valid &&
                      ((rt_q == bus.IF_ID_RegRs) ||
                       (bus.ID_UsesRt && (rt_q == bus.IF_ID_RegRt)));

    // A flushed ID instruction is wrong-path, so there is nothing to hold.
    assign w_stall  = w_hazard && !bus.Flush;
    assign w_bubble = bus.Flush || w_hazard;

    // The regfile is read in the same cycle WB writes it; forward the write
    // data so the captured operand is the new value. $0 is never bypassed.
    assign w_byp1 = (bus.MEM_WB_RegWrite && (bus.MEM_WB_RegRd != '0) &&
                     (bus.MEM_WB_RegRd == bus.IF_ID_RegRs))
                    ? bus.MEM_WB_Data : bus.ID_RegData1;
    assign w_byp2 = (bus.MEM_WB_RegWrite && (bus.MEM_WB_RegRd != '0) &&
                     (bus.MEM_WB_RegRd == bus.IF_ID_RegRt))
                    ? bus.MEM_WB_Data : bus.ID_RegData2;

    always_comb begin
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        ctrl_d  = '0;
        data1_d = '0;
        data2_d = '0;
        imm_d   = '0;
        valid_d = 1'b0;
        if (!w_bubble) begin
            rs_d    = bus.IF_ID_RegRs;
            rt_d    = bus.IF_ID_RegRt;
            rd_d    = bus.IF_ID_RegRd;
            // An empty ID slot must not carry live control into EX.
            ctrl_d  = bus.ID_Valid ? bus.ID_Ctrl : 8'h00;
            data1_d = w_byp1;
            data2_d = w_byp2;
            imm_d   = bus.ID_Imm;
            valid_d = bus.ID_Valid;
        end
    end

    // Saturating stall counter: holds at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (w_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ID_EX_RegRs = rs_q;
    assign bus.ID_EX_RegRt = rt_q;
    assign bus.ID_EX_RegRd = rd_q;
    assign bus.ID_EX_Ctrl  = ctrl_q;
    assign bus.ID_EX_Data1 = data1_q;
    assign bus.ID_EX_Data2 = data2_q;
    assign bus.ID_EX_Imm   = imm_q;
    assign bus.ID_EX_Valid = valid_q;
    assign bus.Stall       = w_stall;
    assign bus.PCWrite     = !w_stall;
    assign bus.IF_IDWrite  = !w_stall;
    assign bus.StallCount  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage_reg
//  Description : Self-checking bench for id_ex_stage_reg: directed pipeline
//                scenarios followed by randomized traffic, compared against
//                a transaction-level model of the EX slot and stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage_reg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;   // narrow so saturation is reachable
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [7:0] C_LW  = 8'h27; // RegWrite|MemtoReg|MemRead|ALUSrc
    localparam logic [7:0] C_ADD = 8'h91; // RegWrite|RegDst|ALUOp=10
    localparam logic [7:0] C_ADDI = 8'h21; // RegWrite|ALUSrc

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) ifc ();

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
        logic [31:0] d1, d2, imm;
        logic        valid;
    } ex_t;

    ex_t m;        // expected EX slot contents
    int  m_cnt;    // expected stall count

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string w);
        check_val({w, ".rs"},    ifc.ID_EX_RegRs, m.rs);
        check_val({w, ".rt"},    ifc.ID_EX_RegRt, m.rt);
        check_val({w, ".rd"},    ifc.ID_EX_RegRd, m.rd);
        check_val({w, ".ctrl"},  ifc.ID_EX_Ctrl,  m.ctrl);
        check_val({w, ".d1"},    ifc.ID_EX_Data1, m.d1);
        check_val({w, ".d2"},    ifc.ID_EX_Data2, m.d2);
        check_val({w, ".imm"},   ifc.ID_EX_Imm,   m.imm);
        check_val({w, ".valid"}, ifc.ID_EX_Valid, m.valid);
        check_val({w, ".cnt"},   ifc.StallCount,  m_cnt);
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic uses_rt,
                          input logic valid, input logic [7:0] ctrl,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm);
        ifc.IF_ID_RegRs = rs;
        ifc.IF_ID_RegRt = rt;
        ifc.IF_ID_RegRd = rd;
        ifc.ID_UsesRt   = uses_rt;
        ifc.ID_Valid    = valid;
        ifc.ID_Ctrl     = ctrl;
        ifc.ID_RegData1 = r1;
        ifc.ID_RegData2 = r2;
        ifc.ID_Imm      = imm;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
        ifc.MEM_WB_RegWrite = we;
        ifc.MEM_WB_RegRd    = rd;
        ifc.MEM_WB_Data     = data;
    endtask

    // Called just after a falling edge with inputs applied. Checks the
    // combinational flow-control outputs, advances one clock and checks the
    // new EX slot against the model.
    task automatic step(input string w);
        bit  dep, stall_exp;
        ex_t nx;
        #1;
        // Does the instruction in ID read a register a load in EX is fetching?
        dep = m.valid && m.ctrl[2] && (m.rt != 0) && ifc.ID_Valid &&
              ((m.rt == ifc.IF_ID_RegRs) ||
               (ifc.ID_UsesRt && m.rt == ifc.IF_ID_RegRt));
        stall_exp = dep && !ifc.Flush;
        check_val({w, ".Stall"},      ifc.Stall,      stall_exp);
        check_val({w, ".PCWrite"},    ifc.PCWrite,    !stall_exp);
        check_val({w, ".IF_IDWrite"}, ifc.IF_IDWrite, !stall_exp);

        nx = '0;
        if (!(ifc.Flush || dep)) begin
            nx.rs    = ifc.IF_ID_RegRs;
            nx.rt    = ifc.IF_ID_RegRt;
            nx.rd    = ifc.IF_ID_RegRd;
            nx.ctrl  = ifc.ID_Valid ? ifc.ID_Ctrl : 8'h00;
            nx.d1    = (ifc.MEM_WB_RegWrite && ifc.MEM_WB_RegRd != 0 &&
                        ifc.MEM_WB_RegRd == ifc.IF_ID_RegRs)
                       ? ifc.MEM_WB_Data : ifc.ID_RegData1;
            nx.d2    = (ifc.MEM_WB_RegWrite && ifc.MEM_WB_RegRd != 0 &&
                        ifc.MEM_WB_RegRd == ifc.IF_ID_RegRt)
                       ? ifc.MEM_WB_Data : ifc.ID_RegData2;
            nx.imm   = ifc.ID_Imm;
            nx.valid = ifc.ID_Valid;
        end
        @(posedge clk);
        #1;
        m = nx;
        if (stall_exp && m_cnt < CNT_MAX) m_cnt++;
        check_regs(w);
        @(negedge clk);
    endtask

    initial begin
        m     = '0;
        m_cnt = 0;
        ifc.Flush = 1'b0;
        set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);

        // Reset state
        #12;
        check_regs("reset");
        check_val("reset.Stall",   ifc.Stall,   1'b0);
        check_val("reset.PCWrite", ifc.PCWrite, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // lw $8,0($1) then add $9,$8,$10: one stall, bubble, then add
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, C_LW, 32'h100, 32'h0, 32'h0);
        step("lw8");
        set_id(5'd8, 5'd10, 5'd9, 1'b1, 1'b1, C_ADD, 32'h11, 32'h22, 32'h0);
        step("lu_stall");
        check_val("lu_bubble_ctrl", ifc.ID_EX_Ctrl, 8'h00);
        check_val("lu_cnt", ifc.StallCount, 1);
        step("lu_add");
        check_val("lu_add_ctrl", ifc.ID_EX_Ctrl, C_ADD);

        // lw $0 then add $9,$0,$2: never stalls
        set_id(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, C_LW, 32'h100, 32'h0, 32'h0);
        step("lw0");
        set_id(5'd0, 5'd2, 5'd9, 1'b1, 1'b1, C_ADD, 32'h0, 32'h5, 32'h0);
        step("r0_nostall");
        check_val("r0_cnt", ifc.StallCount, 1);

        // lw $8 then addi $8,$3,4 (rt is a destination only): no stall
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, C_LW, 32'h100, 32'h0, 32'h0);
        step("lw8b");
        set_id(5'd3, 5'd8, 5'd0, 1'b0, 1'b1, C_ADDI, 32'h33, 32'h0, 32'h4);
        step("addi");
        check_val("addi_ctrl", ifc.ID_EX_Ctrl, C_ADDI);

        // Flush together with a hazard: no stall, bubble, count unchanged
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, C_LW, 32'h100, 32'h0, 32'h0);
        step("lw8c");
        set_id(5'd8, 5'd10, 5'd9, 1'b1, 1'b1, C_ADD, 32'h11, 32'h22, 32'h0);
        ifc.Flush = 1'b1;
        step("flush_hz");
        ifc.Flush = 1'b0;
        check_val("flush_valid", ifc.ID_EX_Valid, 1'b0);
        check_val("flush_cnt",   ifc.StallCount, 1);

        // WB->ID bypass, and no bypass of $0
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        set_id(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, C_ADD, 32'h0, 32'h66, 32'h0);
        step("byp");
        check_val("byp_d1", ifc.ID_EX_Data1, 32'hDEADBEEF);
        set_wb(1'b1, 5'd0, 32'hCAFEF00D);
        set_id(5'd0, 5'd6, 5'd7, 1'b1, 1'b1, C_ADD, 32'h11, 32'h66, 32'h0);
        step("byp_r0");
        check_val("byp_r0_d1", ifc.ID_EX_Data1, 32'h11);
        set_wb(1'b0, 5'd0, 32'h0);

        // ID_Valid=0 captured with control forced off
        set_id(5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 8'hFF, 32'h1, 32'h2, 32'h3);
        step("novalid");

        // Async reset between edges while stalling
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, C_LW, 32'h100, 32'h0, 32'h0);
        step("lw8d");
        set_id(5'd8, 5'd10, 5'd9, 1'b1, 1'b1, C_ADD, 32'h11, 32'h22, 32'h0);
        #1;
        check_val("mid.Stall_pre", ifc.Stall, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        m     = '0;
        m_cnt = 0;
        check_regs("midrst");
        check_val("midrst.Stall",   ifc.Stall,   1'b0);
        check_val("midrst.PCWrite", ifc.PCWrite, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        step("resume");
        check_val("resume_ctrl", ifc.ID_EX_Ctrl, C_ADD);

        // Saturation of the stall counter
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            set_id(5'd1, 5'd9, 5'd0, 1'b0, 1'b1, C_LW, 32'h100, 32'h0, 32'h0);
            step("sat_lw");
            set_id(5'd7, 5'd9, 5'd4, 1'b1, 1'b1, C_ADD, 32'h1, 32'h2, 32'h0);
            step("sat_stall");
            step("sat_add");
        end
        check_val("cnt_sat", ifc.StallCount, CNT_MAX);

        // Randomized traffic from a small register pool
        reset = 1'b0;
        #1;
        m     = '0;
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] c;
            c = 8'($urandom);
            c[2] = ($urandom_range(0, 1) == 1);
            set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 99) < 85), c,
                   $urandom, $urandom, $urandom);
            set_wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            ifc.Flush = ($urandom_range(0, 99) < 10);
            step("rnd");
        end
        ifc.Flush = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
